// File: rtl/pipe_ctrl.sv
// Front-end sequencing controller: start-up delay, load-use stalls, branch
// redirects, halt parking, and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int START_DELAY  = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             PC_write,
    output logic             pc_sel,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (START_DELAY > 0) ? ST_INIT : ST_RUN;
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
    localparam int REM_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [DLY_W-1:0] dly_reg, dly_next;
    logic [REM_W-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;
    logic [CNT_W-1:0] flush_count_reg, flush_count_next;
    logic             stall_evt;
    logic             flush_evt;
    logic             load_use;
    logic             br;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Outputs are combinational, so a redirect must not leak out while reset is held.
    assign br = branch_taken && rst_n;

    always_comb begin
        state_next  = state_reg;
        dly_next    = dly_reg;
        rem_next    = rem_reg;
        PC_write    = 1'b0;
        pc_sel      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;

        case (state_reg)
            ST_INIT: begin
                idex_bubble = 1'b1;
                if (dly_reg <= DLY_W'(1)) begin
                    dly_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    dly_next = dly_reg - DLY_W'(1);
                end
            end

            ST_RUN: begin
                if (br) begin
                    pc_sel      = 1'b1;
                    PC_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_evt   = 1'b1;
                end else if (!en) begin
                    PC_write = 1'b0;
                end else if (load_use) begin
                    idex_bubble = 1'b1;
                    stall_evt   = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_next = ST_STALL;
                        rem_next   = REM_INIT;
                    end
                end else if (halt_req) begin
                    idex_bubble = 1'b1;
                    state_next  = ST_HALT;
                end else begin
                    PC_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end

            ST_STALL: begin
                // A redirect flushes the stalled ID instruction, so the stall is moot.
                if (br) begin
                    pc_sel      = 1'b1;
                    PC_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_evt   = 1'b1;
                    rem_next    = '0;
                    state_next  = ST_RUN;
                end else begin
                    idex_bubble = 1'b1;
                    stall_evt   = 1'b1;
                    if (rem_reg <= REM_W'(1)) begin
                        rem_next   = '0;
                        state_next = ST_RUN;
                    end else begin
                        rem_next = rem_reg - REM_W'(1);
                    end
                end
            end

            ST_HALT: begin
                idex_bubble = 1'b1;
            end

            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        flush_count_next = flush_count_reg;
        if (stall_evt && (stall_count_reg != CNT_MAX)) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
        if (flush_evt && (flush_count_reg != CNT_MAX)) begin
            flush_count_next = flush_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RESET_STATE;
            dly_reg         <= DLY_INIT;
            rem_reg         <= '0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            dly_reg         <= dly_next;
            rem_reg         <= rem_next;
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

    assign state       = state_reg;
    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected state/outputs go through a
// scoreboard queue; counters are tracked by a small saturating model.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum int {C_INIT, C_RUN, C_REDIR, C_EN0, C_STALL, C_HALT} cat_e;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [4:0]  o;
        logic [4:0]  m;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          id_uses_rt = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rt = '0;
    logic          branch_taken = 1'b0;
    logic          halt_req = 1'b0;
    logic          PC_write;
    logic          pc_sel;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic [1:0]    state;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    exp_t          sb_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .STALL_CYCLES(2),
        .START_DELAY (2),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .branch_taken(branch_taken),
        .halt_req    (halt_req),
        .PC_write    (PC_write),
        .pc_sel      (pc_sel),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .state       (state),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {PC_write, pc_sel, ifid_write, ifid_flush, idex_bubble}.
    // Mask bits clear where the behaviour leaves a signal unconstrained.
    function automatic void cat_bits(input cat_e c, output logic [4:0] o, output logic [4:0] m);
        case (c)
            C_INIT:  begin o = 5'b00001; m = 5'b11111; end
            C_RUN:   begin o = 5'b10100; m = 5'b11111; end
            C_REDIR: begin o = 5'b11011; m = 5'b11011; end
            C_EN0:   begin o = 5'b00000; m = 5'b10111; end
            default: begin o = 5'b00001; m = 5'b10101; end
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic e,
                        input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic br,
                        input logic hlt, input logic [1:0] st, input cat_e c);
        exp_t x;
        exp_t y;
        @(posedge clk);
        #1;
        rst_n        = r;
        en           = e;
        ex_mem_read  = mr;
        ex_rt        = ert;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        branch_taken = br;
        halt_req     = hlt;
        if (!r) begin
            m_stall = '0;
            m_flush = '0;
        end
        x.tag = tag;
        x.st  = st;
        cat_bits(c, x.o, x.m);
        x.sc  = m_stall;
        x.fc  = m_flush;
        sb_q.push_back(x);
        @(negedge clk);
        y = sb_q.pop_front();
        chk({y.tag, ".state"}, 32'(state), 32'(y.st));
        chk({y.tag, ".outs"},
            32'({PC_write, pc_sel, ifid_write, ifid_flush, idex_bubble} & y.m),
            32'(y.o & y.m));
        chk({y.tag, ".stall_count"}, 32'(stall_count), 32'(y.sc));
        chk({y.tag, ".flush_count"}, 32'(flush_count), 32'(y.fc));
        $display("step %s: state=%0d outs=%b stall=%0d flush=%0d", y.tag, state,
                 {PC_write, pc_sel, ifid_write, ifid_flush, idex_bubble}, stall_count, flush_count);
        if (r && (c == C_STALL) && (m_stall != CMAX)) m_stall = m_stall + 1'b1;
        if (r && (c == C_REDIR) && (m_flush != CMAX)) m_flush = m_flush + 1'b1;
    endtask

    task automatic idle(input string tag, input logic [1:0] st, input cat_e c);
        step(tag, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, st, c);
    endtask

    task automatic lu(input string tag, input logic [1:0] st, input cat_e c);
        step(tag, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, st, c);
    endtask

    initial begin
        // Reset held, then release: 2-cycle start delay before fetch.
        step("rst0", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, C_INIT);
        step("rst1", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, C_INIT);
        idle("rel0", 2'd0, C_INIT);
        idle("rel1", 2'd0, C_INIT);
        idle("run0", 2'd1, C_RUN);

        // Load-use on rs: two bubble cycles, then RUN.
        lu("lu_rs", 2'd1, C_STALL);
        lu("lu_stall", 2'd2, C_STALL);
        idle("lu_done", 2'd1, C_RUN);
        step("rt_zero", 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, C_RUN);

        // Load-use on rt depends on id_uses_rt.
        step("rt_nouse", 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 2'd1, C_RUN);
        step("rt_use", 1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 2'd1, C_STALL);
        idle("rt_stall", 2'd2, C_STALL);
        idle("rt_back", 2'd1, C_RUN);

        // Redirect beats simultaneous hazard and halt.
        step("redir_all", 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 2'd1, C_REDIR);
        idle("post_redir", 2'd1, C_RUN);
        lu("lu2", 2'd1, C_STALL);
        step("stall_br", 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, C_REDIR);
        idle("abort", 2'd1, C_RUN);

        // Run enable low freezes fetch but not redirects.
        step("en0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, C_EN0);
        step("en0_lu", 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, C_EN0);
        step("en0_br", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd1, C_REDIR);

        // Halt parks the front end; branches ignored; only reset leaves.
        step("halt", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, C_HALT);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("halt%0d", i), 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0,
                 logic'(i % 2), 1'b0, 2'd3, C_HALT);
        end
        step("halt_rst", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, C_INIT);
        idle("hrel0", 2'd0, C_INIT);
        idle("hrel1", 2'd0, C_INIT);
        idle("hrun", 2'd1, C_RUN);

        // Drive well past 2^CW stall events to check saturation.
        for (int i = 0; i < 19; i++) begin
            lu($sformatf("sat%0d_a", i), 2'd1, C_STALL);
            lu($sformatf("sat%0d_b", i), 2'd2, C_STALL);
        end
        idle("sat_end", 2'd1, C_RUN);
        idle("sat_hold", 2'd1, C_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the front end of the five-stage core. It drives the fetch stage's `PC_write` enable and the IF/ID and ID/EX pipeline-register controls. It detects load-use hazards, applies branch redirects and flushes, holds fetch off for a programmable delay after reset, and parks the front end on a halt instruction. It also keeps saturating event counters for stalls and flushes.

## Interface
- `STALL_CYCLES`, default 1: bubbles inserted per load-use hazard (>=1).
- `START_DELAY`, default 2: cycles after reset release before fetch begins (0 allowed).
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  front-end run enable; 0 freezes fetch.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  destination register of the EX load.
- `branch_taken`  in  1  branch resolved taken in EX this cycle.
- `halt_req`  in  1  ID instruction is a halt.
- `PC_write`  out  1  PC advance/load enable to fetch.
- `pc_sel`  out  1  1 = PC loads branch target; 0 = PC+4.
- `ifid_write`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  IF/ID register clear, takes precedence over `ifid_write`.
- `idex_bubble`  out  1  insert a NOP into ID/EX.
- `state`  out  2  current FSM state.
- `stall_count`  out  `CNT_W`  load-use bubble cycles, saturating.
- `flush_count`  out  `CNT_W`  branch redirects, saturating.

## Operation
- Hazard term: `load_use = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.
- State encodings: INIT=0, RUN=1, STALL=2, HALT=3.
- Reset state:
  - `START_DELAY` > 0: reset enters INIT and loads the delay counter with `START_DELAY`.
  - `START_DELAY` = 0: reset enters RUN.
- INIT:
  - Outputs: `PC_write=0`, `ifid_write=0`, `ifid_flush=0`, `idex_bubble=1`, `pc_sel=0`.
  - The delay counter decrements each cycle; the FSM moves to RUN on the edge where the counter reaches 0.
  - All other inputs are ignored.
- RUN: conditions are evaluated in strict priority order, first match wins.
  1. `branch_taken`: `pc_sel=1`, `PC_write=1`, `ifid_flush=1`, `idex_bubble=1`. `flush_count` increments. Stay in RUN. This applies regardless of `en`.
  2. `en=0`: `PC_write=0`, `ifid_write=0`, `idex_bubble=0`, `ifid_flush=0`. Stay in RUN.
  3. `load_use`: `PC_write=0`, `ifid_write=0`, `idex_bubble=1`. `stall_count` increments. Next state is STALL with remaining count `STALL_CYCLES-1` if `STALL_CYCLES` > 1; otherwise stay in RUN.
  4. `halt_req`: `PC_write=0`, `ifid_write=0`, `idex_bubble=1`. Next state is HALT.
  5. Otherwise: `PC_write=1`, `ifid_write=1`, `pc_sel=0`, `idex_bubble=0`, `ifid_flush=0`.
- STALL:
  - Outputs: same as RUN case 3. `stall_count` increments each cycle.
  - The remaining count decrements; return to RUN when it hits 0.
  - `branch_taken` overrides: apply the RUN redirect outputs, abort the stall, next state RUN.
  - `en` is ignored in STALL.
- HALT:
  - Outputs: `PC_write=0`, `ifid_write=0`, `idex_bubble=1`, `ifid_flush=0`.
  - `branch_taken` is ignored.
  - HALT is left only through `rst_n`.
- Counters: reset to 0, increment by 1, hold at all-ones (no wrap).

## Timing
- All control outputs are combinational from the registered state and current-cycle inputs, so hazard-to-stall latency is 0 cycles.
- `state`, the counters, the delay counter and the stall-remaining counter are registered.
- Counter increments are visible on the cycle after the triggering event.
- Values while `rst_n`=0 (asynchronous):
  - `state` = INIT (or RUN if `START_DELAY`=0).
  - Counters = 0.
  - Outputs take the reset state's values, evaluated with `branch_taken` treated as 0.
- Reset asserted mid-STALL or in HALT: the FSM immediately returns to the reset state. Partial stall and delay counts are discarded.
- Simultaneous `branch_taken`, `load_use` and `halt_req`: the redirect wins. The hazard and halt are dropped, because the ID instruction is flushed.
- With default parameters, the first `PC_write=1` occurs in the 3rd cycle after `rst_n` deasserts.

## Test plan
- Reset release, `START_DELAY`=2, `en`=1, no hazards → `state` reads 0,0,1. `PC_write` reads 0,0,1. `idex_bubble` reads 1,1,0.
- `ex_mem_read=1`, `ex_rt=5`, `id_rs=5`, `STALL_CYCLES=2` → 2 cycles of `PC_write=0` and `idex_bubble=1`, then RUN. `stall_count` ends at 2. Repeat with `ex_rt=0` → no stall.
- `id_rt=7`, `ex_rt=7`, `ex_mem_read=1`, `id_uses_rt` toggled 0/1 → stall only when `id_uses_rt=1`.
- `branch_taken=1` together with `load_use` and `halt_req` → `pc_sel=1`, `PC_write=1`, `ifid_flush=1`. `flush_count`=1, `stall_count` unchanged, `state` stays RUN. Repeat mid-STALL → stall aborted.
- `halt_req=1` → HALT (`state`=3) and `PC_write=0` held for 10+ cycles despite `branch_taken` pulses. `rst_n` pulse → INIT, counters 0.
- Force 2^`CNT_W`+3 stalls with `CNT_W`=4 → `stall_count` saturates at 15. `en=0` in RUN → `PC_write=0`, `idex_bubble=0`.
